// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin grant of one finished FU result per cycle onto a registered CDB broadcast
module cdb_arbiter #(
  parameter int NUM_FU        = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int ROB_IDX_WIDTH = 3,
  localparam int SRC_W        = $clog2(NUM_FU)
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            flush_in,
  input  logic                            rob_ready_in,
  input  logic [NUM_FU-1:0]               fu_valid_in,
  input  logic [NUM_FU*DATA_WIDTH-1:0]    fu_data_in,
  input  logic [NUM_FU*ROB_IDX_WIDTH-1:0] fu_rob_idx_in,
  output logic [NUM_FU-1:0]               fu_read_out,
  output logic                            cdb_valid_out,
  output logic [DATA_WIDTH-1:0]           cdb_data_out,
  output logic [ROB_IDX_WIDTH-1:0]        cdb_rob_idx_out,
  output logic [SRC_W-1:0]                cdb_src_out
);
  logic [SRC_W-1:0]         r_ptr;
  logic                     r_valid;
  logic [DATA_WIDTH-1:0]    r_data;
  logic [ROB_IDX_WIDTH-1:0] r_idx;
  logic [SRC_W-1:0]         r_src;
  logic                     w_en;
  logic                     w_any;
  logic                     w_grant;
  logic [SRC_W-1:0]         w_g;
  assign w_en    = !rst_in && rob_ready_in && !flush_in;
  assign w_grant = w_en && w_any;
  // Scan from the farthest offset down so the nearest valid FU after ptr wins.
  always_comb begin
    w_any = 1'b0;
    w_g   = '0;
    for (int i = NUM_FU - 1; i >= 0; i--) begin
      if (fu_valid_in[(int'(r_ptr) + i) % NUM_FU]) begin
        w_any = 1'b1;
        w_g   = SRC_W'((int'(r_ptr) + i) % NUM_FU);
      end
    end
  end
  always_comb begin
    fu_read_out = '0;
    if (w_grant) fu_read_out[w_g] = 1'b1;
  end
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_ptr   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_idx   <= '0;
      r_src   <= '0;
    end else begin
      r_valid <= w_grant;
      if (w_grant) begin
        r_data <= fu_data_in[int'(w_g)*DATA_WIDTH +: DATA_WIDTH];
        r_idx  <= fu_rob_idx_in[int'(w_g)*ROB_IDX_WIDTH +: ROB_IDX_WIDTH];
        r_src  <= w_g;
        r_ptr  <= (w_g == SRC_W'(NUM_FU - 1)) ? '0 : w_g + 1'b1;
      end
    end
  end
  assign cdb_valid_out   = r_valid;
  assign cdb_data_out    = r_data;
  assign cdb_rob_idx_out = r_idx;
  assign cdb_src_out     = r_src;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: scenario tasks with a round-robin model feeding an expected-broadcast queue
module tb_cdb_arbiter;
  localparam int N = 5, DW = 32, RW = 3, SW = 3;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, ready = 1'b1;
  logic [N-1:0]    valid = '0;
  logic [N*DW-1:0] data  = '0;
  logic [N*RW-1:0] rob   = '0;
  logic [N-1:0]    rd;
  logic            cdb_valid;
  logic [DW-1:0]   cdb_data;
  logic [RW-1:0]   cdb_idx;
  logic [SW-1:0]   cdb_src;
  typedef struct packed {logic [DW-1:0] d; logic [RW-1:0] r; logic [SW-1:0] s;} bc_t;
  bc_t q[$];
  int  m_ptr = 0, n_tests = 0, n_fail = 0;
  bit  sticky = 1'b0;

  cdb_arbiter #(.NUM_FU(N), .DATA_WIDTH(DW), .ROB_IDX_WIDTH(RW)) dut (
    .clk_in(clk), .rst_in(rst), .flush_in(flush), .rob_ready_in(ready),
    .fu_valid_in(valid), .fu_data_in(data), .fu_rob_idx_in(rob),
    .fu_read_out(rd), .cdb_valid_out(cdb_valid), .cdb_data_out(cdb_data),
    .cdb_rob_idx_out(cdb_idx), .cdb_src_out(cdb_src));

  always #5 clk = ~clk;

  task automatic set_fu(input int k, input logic [DW-1:0] d, input logic [RW-1:0] r);
    data[k*DW +: DW] = d;
    rob[k*RW +: RW]  = r;
    valid[k]         = 1'b1;
  endtask

  // Called at a negedge with inputs settled; ends at the next negedge.
  task automatic cycle(input string nm);
    int g;
    logic [N-1:0] ex;
    bc_t e;
    #1;
    g  = -1;
    ex = '0;
    if (!rst && ready && !flush)
      for (int i = N - 1; i >= 0; i--) if (valid[(m_ptr + i) % N]) g = (m_ptr + i) % N;
    if (g >= 0) begin
      ex[g] = 1'b1;
      q.push_back({data[g*DW +: DW], rob[g*RW +: RW], SW'(g)});
      m_ptr = (g + 1) % N;
    end
    n_tests++;
    if (rd !== ex) begin
      n_fail++;
      $display("FAIL %s grant: got %b want %b", nm, rd, ex);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (g >= 0) begin
      e = q.pop_front();
      if (cdb_valid !== 1'b1 || cdb_data !== e.d || cdb_idx !== e.r || cdb_src !== e.s) begin
        n_fail++;
        $display("FAIL %s cdb: got v=%b d=%h i=%0d s=%0d want v=1 d=%h i=%0d s=%0d",
                 nm, cdb_valid, cdb_data, cdb_idx, cdb_src, e.d, e.r, e.s);
      end
    end else if (cdb_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s cdb_valid: got %b want 0", nm, cdb_valid);
    end
    if (g >= 0 && !sticky) valid[g] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2;
    n_tests++;
    if (rd !== '0 || cdb_valid !== 1'b0 || cdb_data !== '0 || cdb_idx !== '0 || cdb_src !== '0) begin
      n_fail++;
      $display("FAIL reset: got rd=%b v=%b d=%h i=%0d s=%0d want all 0", rd, cdb_valid, cdb_data, cdb_idx, cdb_src);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_all_valid();
    sticky = 1'b1;
    for (int k = 0; k < N; k++) set_fu(k, 32'hA000_0000 + k, RW'(k + 1));
    for (int c = 0; c < 6; c++) cycle("all_valid");
    valid  = '0;
    sticky = 1'b0;
  endtask

  task automatic test_single();
    set_fu(2, 32'h0000_00AB, 3'd5);
    cycle("single_fu2");
    cycle("single_idle");
  endtask

  task automatic test_wrap();
    set_fu(1, 32'h1111_0001, 3'd3);
    set_fu(4, 32'h4444_0004, 3'd6);
    cycle("wrap_fu4");
    cycle("wrap_fu1");
    set_fu(1, 32'h1111_0002, 3'd2);
    set_fu(2, 32'h2222_0002, 3'd4);
    cycle("wrap_ptr2");
    cycle("wrap_next");
  endtask

  task automatic test_flush();
    set_fu(0, 32'hF0F0_0000, 3'd1);
    flush = 1'b1;
    cycle("flush_hold");
    flush = 1'b0;
    cycle("flush_release");
    set_fu(3, 32'h3333_0003, 3'd0);
    cycle("flush_issue");
    flush = 1'b1;
    cycle("flush_after_bc");
    flush = 1'b0;
    cycle("flush_done");
  endtask

  task automatic test_backpressure();
    set_fu(1, 32'hBEEF_0001, 3'd7);
    ready = 1'b0;
    for (int c = 0; c < 3; c++) cycle("bp_hold");
    ready = 1'b1;
    cycle("bp_release");
    cycle("bp_idle");
  endtask

  task automatic test_reset_mid();
    sticky = 1'b1;
    for (int k = 0; k < N; k++) set_fu(k, 32'hC000_0010 + k, RW'(k));
    cycle("mid_pre0");
    cycle("mid_pre1");
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (rd !== '0 || cdb_valid !== 1'b0 || cdb_data !== '0 || cdb_idx !== '0 || cdb_src !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got rd=%b v=%b d=%h i=%0d s=%0d want all 0", rd, cdb_valid, cdb_data, cdb_idx, cdb_src);
    end
    q.delete();
    m_ptr = 0;
    @(negedge clk);
    rst = 1'b0;
    cycle("mid_first_fu0");
    cycle("mid_second");
    valid  = '0;
    sticky = 1'b0;
  endtask

  task automatic test_random();
    logic [N-1:0] nv;
    for (int c = 0; c < 60; c++) begin
      nv = N'($urandom_range(0, (1 << N) - 1));
      for (int k = 0; k < N; k++)
        if (nv[k] && !valid[k]) set_fu(k, DW'($urandom), RW'($urandom_range(0, 7)));
      ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 7) == 0);
      cycle("random");
    end
    ready = 1'b1;
    flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_all_valid();
    test_single();
    test_wrap();
    test_flush();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
